// File: rtl/axi_posit_adder_s_axi_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_posit_adder_s_axi_if
// Purpose  : AXI4-Lite bus bundle between the bus master (VIP / bench) and
//            the posit adder register front end.
// Modports : master - drives addresses, write data, VALIDs and BREADY/RREADY
//            slave  - drives READYs, BVALID/BRESP and RVALID/RDATA/RRESP
// Revision : 1.0 - initial release
// ============================================================================
interface axi_posit_adder_s_axi_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);

  // Write address channel
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  // Write data channel
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  // Write response channel
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  // Read address channel
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  // Read data channel
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

endinterface
`default_nettype wire

// File: rtl/axi_posit_adder_s_axi.sv
`default_nettype none
// ============================================================================
// Module   : axi_posit_adder_s_axi
// Purpose  : AXI4-Lite register front end for the posit adder core. Holds
//            operands A/B, launches one addition through a valid/ready
//            handshake and captures the sum.
//
// Register map (word addressed by addr[3:2]):
//   0x0 OPA    R/W, byte strobed
//   0x4 OPB    R/W, byte strobed
//   0x8 CTRL   bit0 START (W1 launch, reads 0), bit1 BUSY (RO),
//              bit2 DONE (RO, W1C), bits 31:3 read 0
//   0xC RESULT RO (writes ignored, still answered OKAY)
//
// Ports:
//   ACLK, ARESETN      clock (rising edge) / async active-low reset
//   s_axi              AXI4-Lite slave modport
//   op_a, op_b         operand snapshot presented to the core
//   op_valid/op_ready  launch handshake towards the core
//   res_data/res_valid sum from the core, single-cycle strobe
//
// Revision : 1.0 - initial release
// ============================================================================
module axi_posit_adder_s_axi #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int POSIT_N            = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  axi_posit_adder_s_axi_if.slave  s_axi,
  output logic [POSIT_N-1:0]      op_a,
  output logic [POSIT_N-1:0]      op_b,
  output logic                    op_valid,
  input  logic                    op_ready,
  input  logic [POSIT_N-1:0]      res_data,
  input  logic                    res_valid
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;

  // --------------------------------------------------------------------------
  // Reset: asserted asynchronously, released on a clock edge so that no flop
  // sees ARESETN rising close to ACLK.
  // --------------------------------------------------------------------------
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  // --------------------------------------------------------------------------
  // Write channel FSM
  // AWREADY/WREADY are raised combinationally only in W_IDLE and only when
  // both VALIDs are present, so address and data are always taken together
  // and the register update happens on that same edge.
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  wr_state_t wr_state, wr_state_nxt;
  logic      aw_ready, w_ready, b_valid;
  logic      wr_fire;

  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= W_IDLE;
    end else begin
      wr_state <= wr_state_nxt;
    end
  end

  always_comb begin
    wr_state_nxt = wr_state;
    aw_ready     = 1'b0;
    w_ready      = 1'b0;
    b_valid      = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
          aw_ready     = 1'b1;
          w_ready      = 1'b1;
          wr_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (s_axi.S_AXI_BREADY) begin
          wr_state_nxt = W_IDLE;
        end
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  assign wr_fire             = aw_ready;
  assign s_axi.S_AXI_AWREADY = aw_ready;
  assign s_axi.S_AXI_WREADY  = w_ready;
  assign s_axi.S_AXI_BVALID  = b_valid;
  assign s_axi.S_AXI_BRESP   = 2'b00;

  // --------------------------------------------------------------------------
  // Read channel FSM
  // RDATA is captured on the ARREADY edge and held until RREADY, so a read
  // racing a write to the same register sees the pre-write contents.
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  rd_state_t         rd_state, rd_state_nxt;
  logic              ar_ready, r_valid;
  logic              rd_fire;
  logic [DW-1:0]     rd_mux;
  logic [DW-1:0]     rdata;

  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= R_IDLE;
    end else begin
      rd_state <= rd_state_nxt;
    end
  end

  always_comb begin
    rd_state_nxt = rd_state;
    ar_ready     = 1'b0;
    r_valid      = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (s_axi.S_AXI_ARVALID) begin
          ar_ready     = 1'b1;
          rd_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        r_valid = 1'b1;
        if (s_axi.S_AXI_RREADY) begin
          rd_state_nxt = R_IDLE;
        end
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  assign rd_fire             = ar_ready;
  assign s_axi.S_AXI_ARREADY = ar_ready;
  assign s_axi.S_AXI_RVALID  = r_valid;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign s_axi.S_AXI_RDATA   = rdata;

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  logic [DW-1:0]      opa, opb, result;
  logic [DW-1:0]      strb_mask;
  logic [DW-1:0]      res_ext;
  logic [1:0]         wr_sel;
  logic               busy, done;
  logic [POSIT_N-1:0] snap_a, snap_b;

  assign wr_sel = s_axi.S_AXI_AWADDR[3:2];

  // Expand WSTRB into a per-bit mask for the operand registers.
  for (genvar b = 0; b < NB; b++) begin : g_strb_mask
    assign strb_mask[b*8 +: 8] = {8{s_axi.S_AXI_WSTRB[b]}};
  end

  // The core may be narrower than the bus; RESULT is zero-extended.
  if (POSIT_N == DW) begin : g_res_full
    assign res_ext = res_data;
  end else begin : g_res_pad
    assign res_ext = {{(DW-POSIT_N){1'b0}}, res_data};
  end

  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      opa <= '0;
      opb <= '0;
    end else if (wr_fire) begin
      if (wr_sel == 2'd0) begin
        opa <= (opa & ~strb_mask) | (s_axi.S_AXI_WDATA & strb_mask);
      end
      if (wr_sel == 2'd1) begin
        opb <= (opb & ~strb_mask) | (s_axi.S_AXI_WDATA & strb_mask);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Operation sequencing
  // --------------------------------------------------------------------------
  logic ctrl_wr, start_req, clr_req, launch, capture;

  assign ctrl_wr   = wr_fire && (wr_sel == 2'd2) && s_axi.S_AXI_WSTRB[0];
  assign start_req = ctrl_wr && s_axi.S_AXI_WDATA[0];
  assign clr_req   = ctrl_wr && s_axi.S_AXI_WDATA[2];
  // START while an operation is outstanding is silently dropped.
  assign launch    = start_req && !busy;
  // A stray result strobe with nothing outstanding is dropped.
  assign capture   = res_valid && busy;

  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      op_valid <= 1'b0;
      snap_a   <= '0;
      snap_b   <= '0;
      result   <= '0;
    end else begin
      if (op_valid && op_ready) begin
        op_valid <= 1'b0;
      end
      if (capture) begin
        // Setting DONE takes priority over a coincident W1C of DONE.
        result   <= res_ext;
        busy     <= 1'b0;
        done     <= 1'b1;
        op_valid <= 1'b0;
      end else begin
        if (clr_req) begin
          done <= 1'b0;
        end
        if (launch) begin
          busy     <= 1'b1;
          done     <= 1'b0;
          op_valid <= 1'b1;
          snap_a   <= opa[POSIT_N-1:0];
          snap_b   <= opb[POSIT_N-1:0];
        end
      end
    end
  end

  // Operands come from the launch snapshot so later OPA/OPB writes cannot
  // disturb an addition in flight.
  assign op_a = snap_a;
  assign op_b = snap_b;

  // --------------------------------------------------------------------------
  // Read data mux and capture
  // --------------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    case (s_axi.S_AXI_ARADDR[3:2])
      2'd0:    rd_mux = opa;
      2'd1:    rd_mux = opb;
      2'd2:    rd_mux = {{(DW-3){1'b0}}, done, busy, 1'b0};
      default: rd_mux = result;
    endcase
  end

  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_fire) begin
      rdata <= rd_mux;
    end
  end

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi_posit_adder_s_axi.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_posit_adder_s_axi
// Purpose  : Directed self-checking bench for the posit adder AXI4-Lite
//            front end; the bench itself plays both the bus master and the
//            posit adder core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_posit_adder_s_axi;

  localparam int TMO = 50;

  logic        ACLK;
  logic        ARESETN;
  logic [31:0] op_a, op_b;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] res_data;
  logic        res_valid;

  int checks   = 0;
  int failures = 0;
  int hs_count = 0;

  axi_posit_adder_s_axi_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) bus ();

  axi_posit_adder_s_axi #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .POSIT_N(32)
  ) dut (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .s_axi    (bus),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .res_data (res_data),
    .res_valid(res_valid)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Count accepted launch handshakes towards the core.
  always @(posedge ACLK) begin
    if (op_valid && op_ready) hs_count <= hs_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Complete a write response; entered one step after a clock edge.
  task automatic finish_b(output logic [1:0] resp);
    int n = 0;
    bus.S_AXI_BREADY = 1'b1;
    while (!bus.S_AXI_BVALID && n < TMO) begin
      @(posedge ACLK); #1; n++;
    end
    if (n >= TMO) chk("b_timeout", 32'(n), 32'(TMO - 1));
    resp = bus.S_AXI_BRESP;
    @(posedge ACLK); #1;
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n = 0;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    #1;
    while (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY) && n < TMO) begin
      @(posedge ACLK); #1; n++;
    end
    if (n >= TMO) chk("aw_timeout", 32'(n), 32'(TMO - 1));
    @(posedge ACLK); #1;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    finish_b(resp);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n = 0;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    #1;
    while (!bus.S_AXI_ARREADY && n < TMO) begin
      @(posedge ACLK); #1; n++;
    end
    if (n >= TMO) chk("ar_timeout", 32'(n), 32'(TMO - 1));
    @(posedge ACLK); #1;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b1;
    n = 0;
    while (!bus.S_AXI_RVALID && n < TMO) begin
      @(posedge ACLK); #1; n++;
    end
    if (n >= TMO) chk("r_timeout", 32'(n), 32'(TMO - 1));
    data = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    @(posedge ACLK); #1;
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic pulse_ready();
    op_ready = 1'b1;
    @(posedge ACLK); #1;
    op_ready = 1'b0;
  endtask

  task automatic pulse_result(input logic [31:0] val);
    res_data  = val;
    res_valid = 1'b1;
    @(posedge ACLK); #1;
    res_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp;
    int          hs_base;

    ARESETN = 1'b0;
    op_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;

    // ---------------- reset and readback ----------------
    #200;
    chk("rst_op_valid", 32'(op_valid), 32'h0);
    chk("rst_rvalid",   32'(bus.S_AXI_RVALID), 32'h0);
    chk("rst_bvalid",   32'(bus.S_AXI_BVALID), 32'h0);
    chk("rst_rdata",    bus.S_AXI_RDATA, 32'h0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    repeat (4) @(posedge ACLK);
    #1;

    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd, rsp);
      chk($sformatf("rst_reg%0d", i), rd, 32'h0);
      chk($sformatf("rst_rresp%0d", i), 32'(rsp), 32'h0);
    end

    axi_write(4'h0, 32'h0000_0001, 4'hF, rsp);
    axi_write(4'h4, 32'h0000_0002, 4'hF, rsp);
    axi_read(4'h0, rd, rsp); chk("rb_opa", rd, 32'h0000_0001);
    axi_read(4'h4, rd, rsp); chk("rb_opb", rd, 32'h0000_0002);

    // ---------------- byte strobes ----------------
    axi_write(4'h0, 32'hFFFF_FFFF, 4'hF, rsp);
    axi_write(4'h0, 32'h1234_5678, 4'b0101, rsp);
    axi_read(4'h0, rd, rsp); chk("strb_opa", rd, 32'hFF34_FF78);

    // ---------------- addition 1.0 + 1.0 ----------------
    hs_base = hs_count;
    axi_write(4'h0, 32'h4000_0000, 4'hF, rsp);
    axi_write(4'h4, 32'h4000_0000, 4'hF, rsp);
    axi_write(4'h8, 32'h0000_0001, 4'hF, rsp);
    chk("add_bresp", 32'(rsp), 32'h0);
    chk("add_op_valid", 32'(op_valid), 32'h1);
    chk("add_op_a", op_a, 32'h4000_0000);
    chk("add_op_b", op_b, 32'h4000_0000);
    for (int i = 0; i < 3; i++) begin
      @(posedge ACLK); #1;
      chk($sformatf("add_hold%0d", i), 32'(op_valid), 32'h1);
    end
    axi_read(4'h8, rd, rsp); chk("add_ctrl_busy", rd, 32'h0000_0002);
    pulse_ready();
    chk("add_op_valid_drop", 32'(op_valid), 32'h0);
    chk("add_hs", 32'(hs_count - hs_base), 32'h1);
    pulse_result(32'h4800_0000);
    axi_read(4'h8, rd, rsp); chk("add_ctrl_done", rd, 32'h0000_0004);
    axi_read(4'hC, rd, rsp); chk("add_result", rd, 32'h4800_0000);

    // ---------------- START while BUSY ----------------
    hs_base = hs_count;
    axi_write(4'h4, 32'h3800_0000, 4'hF, rsp);
    axi_write(4'h8, 32'h0000_0001, 4'hF, rsp);
    axi_write(4'h8, 32'h0000_0001, 4'hF, rsp);
    chk("busy_start_bresp", 32'(rsp), 32'h0);
    axi_write(4'h4, 32'h1111_1111, 4'hF, rsp);
    chk("busy_op_b_frozen", op_b, 32'h3800_0000);
    axi_read(4'h4, rd, rsp); chk("busy_opb_reg", rd, 32'h1111_1111);
    pulse_ready();
    axi_write(4'h8, 32'h0000_0001, 4'hF, rsp);
    chk("busy_no_relaunch", 32'(op_valid), 32'h0);
    axi_write(4'hC, 32'hDEAD_BEEF, 4'hF, rsp);
    chk("result_wr_bresp", 32'(rsp), 32'h0);
    axi_read(4'hC, rd, rsp); chk("result_wr_ignored", rd, 32'h4800_0000);
    pulse_result(32'h4400_0000);
    chk("busy_hs_once", 32'(hs_count - hs_base), 32'h1);
    axi_read(4'hC, rd, rsp); chk("busy_result", rd, 32'h4400_0000);
    axi_read(4'h8, rd, rsp); chk("busy_ctrl_done", rd, 32'h0000_0004);
    axi_write(4'h8, 32'h0000_0004, 4'hF, rsp);
    axi_read(4'h8, rd, rsp); chk("w1c_done", rd, 32'h0000_0000);

    // ---------------- AW ahead of W, B backpressure ----------------
    bus.S_AXI_AWADDR = 4'h0; bus.S_AXI_WDATA = 32'hA5A5_A5A5; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1;
    #1; chk("aw_only0", 32'(bus.S_AXI_AWREADY), 32'h0);
    @(posedge ACLK); #1; chk("aw_only1", 32'(bus.S_AXI_AWREADY), 32'h0);
    @(posedge ACLK); #1;
    bus.S_AXI_WVALID = 1'b1;
    #1;
    chk("aw_w_awready", 32'(bus.S_AXI_AWREADY), 32'h1);
    chk("aw_w_wready",  32'(bus.S_AXI_WREADY),  32'h1);
    @(posedge ACLK); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bhold%0d", i), 32'(bus.S_AXI_BVALID), 32'h1);
      @(posedge ACLK); #1;
    end
    bus.S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AXI_BREADY = 1'b0;
    chk("b_released", 32'(bus.S_AXI_BVALID), 32'h0);

    // ---------------- R backpressure: RDATA stable across a write ----------------
    bus.S_AXI_ARADDR = 4'h0; bus.S_AXI_ARVALID = 1'b1;
    #1; chk("rhold_arready", 32'(bus.S_AXI_ARREADY), 32'h1);
    @(posedge ACLK); #1;
    bus.S_AXI_ARVALID = 1'b0;
    chk("rhold_rvalid", 32'(bus.S_AXI_RVALID), 32'h1);
    axi_write(4'h0, 32'h5A5A_5A5A, 4'hF, rsp);
    chk("rhold_rvalid2", 32'(bus.S_AXI_RVALID), 32'h1);
    chk("rhold_rdata", bus.S_AXI_RDATA, 32'hA5A5_A5A5);
    bus.S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AXI_RREADY = 1'b0;
    chk("r_released", 32'(bus.S_AXI_RVALID), 32'h0);

    // ---------------- concurrent read/write of OPA ----------------
    bus.S_AXI_AWADDR = 4'h0; bus.S_AXI_WDATA = 32'h1212_1212; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_ARADDR = 4'h0;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    #1;
    chk("conc_awready", 32'(bus.S_AXI_AWREADY), 32'h1);
    chk("conc_arready", 32'(bus.S_AXI_ARREADY), 32'h1);
    @(posedge ACLK); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    chk("conc_old_data", bus.S_AXI_RDATA, 32'h5A5A_5A5A);
    bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
    axi_read(4'h0, rd, rsp); chk("conc_new_data", rd, 32'h1212_1212);

    // ---------------- W1C of DONE coincident with result ----------------
    axi_write(4'h8, 32'h0000_0001, 4'hF, rsp);
    pulse_ready();
    bus.S_AXI_AWADDR = 4'h8; bus.S_AXI_WDATA = 32'h0000_0004; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    res_data = 32'h5000_0000; res_valid = 1'b1;
    #1; chk("w1c_coinc_ready", 32'(bus.S_AXI_AWREADY), 32'h1);
    @(posedge ACLK); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; res_valid = 1'b0;
    finish_b(rsp);
    axi_read(4'h8, rd, rsp); chk("w1c_coinc_done", rd, 32'h0000_0004);
    axi_read(4'hC, rd, rsp); chk("w1c_coinc_result", rd, 32'h5000_0000);

    // ---------------- reset mid-operation ----------------
    axi_write(4'h8, 32'h0000_0005, 4'hF, rsp);
    chk("rst_mid_op_valid", 32'(op_valid), 32'h1);
    #2;
    ARESETN = 1'b0;
    #1;
    chk("rst_mid_async", 32'(op_valid), 32'h0);
    #20;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    repeat (4) @(posedge ACLK);
    #1;
    pulse_result(32'h7777_7777);
    axi_read(4'hC, rd, rsp); chk("rst_mid_result", rd, 32'h0);
    axi_read(4'h8, rd, rsp); chk("rst_mid_ctrl", rd, 32'h0);
    axi_read(4'h0, rd, rsp); chk("rst_mid_opa", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_posit_adder_s_axi.md
Name: axi_posit_adder_s_axi

Overview:
- AXI4-Lite slave register front end for the posit adder IP; it is the responder at the other end of the bus driven by the AXI VIP master in the block-design bench.
- Holds operands A and B, launches one addition on the external posit adder core through a valid/ready handshake, and captures the result.
- Exposes control, status and result to the bus master via four word registers.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, bus data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; decode uses addr[3:2].
- POSIT_N, 32, posit word width on the core interface; must be ≤ C_S_AXI_DATA_WIDTH.

Ports:
- ACLK  in  1  clock; all logic is rising-edge.
- ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00 (OKAY).
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake.
- op_a, op_b  out  POSIT_N  operands to the core, driven from OPA/OPB.
- op_valid / op_ready  out/in  1  operation launch handshake.
- res_data  in  POSIT_N  sum from the core.
- res_valid  in  1  single-cycle result strobe.

Behaviour:
Register map:
- 0x0 OPA: read/write, byte-strobed.
- 0x4 OPB: read/write, byte-strobed.
- 0x8 CTRL:
  - bit0 START: write 1 to launch; always reads 0.
  - bit1 BUSY: read-only.
  - bit2 DONE: read-only; write 1 to clear.
  - bits 31:3: read 0.
- 0xC RESULT: read-only; writes are ignored but still get an OKAY response.

Reset (async assert, sync deassert on ACLK):
- All registers, BUSY, DONE = 0.
- All READY/VALID outputs = 0; op_valid = 0.
- RDATA = 0.

Write FSM:
- W_IDLE: when AWVALID and WVALID are both high, assert AWREADY and WREADY together for exactly one cycle and perform the register write in that cycle. Go to W_RESP.
- W_RESP: BVALID = 1 until BREADY is sampled high, then return to W_IDLE.
- AW without W, or W without AW: no acceptance; wait.
- Minimum write cost: 2 cycles per transaction (no pipelining).

Read FSM:
- R_IDLE: on ARVALID, pulse ARREADY for one cycle, latch RDATA from the register selected by ARADDR[3:2], and go to R_DATA.
- R_DATA: RVALID = 1 and RDATA held stable until RREADY, then return to R_IDLE.
- Read latency: RVALID is high the cycle after the ARREADY handshake.
- The read and write FSMs run independently. A same-cycle read of a register being written returns the old value.

Operation sequencing:
- START=1 written while BUSY=0:
  - Next cycle: BUSY=1, DONE=0, op_valid=1, op_a/op_b = OPA/OPB snapshot.
  - op_valid holds until the first cycle with op_ready=1; it drops the following cycle.
  - The snapshot is frozen while BUSY; later OPA/OPB writes do not alter op_a/op_b.
- START while BUSY: ignored; OKAY response.
- res_valid while BUSY: RESULT ← res_data, zero-extended to 32 bits; BUSY=0, DONE=1, same edge.
- res_valid while not BUSY: ignored.
- DONE write-1-clear in the same cycle as the res_valid capture: set wins, DONE=1.
- START write with bit2=1 (clear DONE) in the same transaction: DONE=0, then launch.
- Reset mid-operation: everything returns to reset values immediately, op_valid included. A res_valid arriving after reset is ignored.

Test Plan:
- Reset and readback: hold ARESETN low for 200 ns, release. Read 0x0, 0x4, 0x8, 0xC -> all 0x00000000, RRESP=0. Write 0x0=0x00000001, 0x4=0x00000002 -> read back 0x00000001 and 0x00000002.
- Byte strobes: write OPA=0xFFFFFFFF, then write 0x12345678 with WSTRB=4'b0101 -> read OPA = 0xFF34FF78.
- Addition: OPA=0x40000000 (1.0), OPB=0x40000000, write CTRL=0x1.
  - op_valid rises one cycle later with op_a=op_b=0x40000000.
  - Bench holds op_ready low 3 cycles -> op_valid stays high throughout.
  - Bench returns res_data=0x48000000 -> CTRL reads 0x4, RESULT reads 0x48000000.
- START while BUSY: write CTRL=0x1 twice before res_valid -> exactly one op_valid handshake. Write OPB mid-op -> op_b unchanged. RESULT write of 0xDEADBEEF -> BRESP=0, RESULT unchanged.
- Handshake ordering and backpressure:
  - AWVALID 2 cycles before WVALID -> AWREADY and WREADY fire in the same cycle.
  - BREADY held low 5 cycles -> BVALID stays high.
  - RREADY held low -> RDATA stable.
  - Concurrent read of 0x0 and write of 0x0 -> read returns the old value.
- Corner events:
  - W1C of DONE coincident with res_valid -> DONE=1.
  - ARESETN asserted while op_valid=1 -> op_valid=0 with no clock edge. A later res_valid -> RESULT stays 0.
